// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared funct3 encodings and MEM-stage FSM state type
// Purpose: constants shared by mem_access and load_extend.
// Ports: none (package).
package riscv_pkg;

  // Load/store access-size encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // MEM-stage FSM state.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_WAIT = 1'b1;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - byte/half lane select and sign/zero extension of load data
// Purpose: turns a 32-bit cache word into the architectural load result.
// Ports:
//   rdata_i  [31:0] word returned by the data cache
//   addr_i   [1:0]  low effective-address bits (lane select)
//   f3_i     [2:0]  funct3 access size / signedness
//   result_o [31:0] extended load value
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  f3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    // addr_i[0] is ignored for halfwords: the naturally aligned lane is used.
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (f3_i)
      F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result_o = {24'h0, byte_sel};
      F3_HU:   result_o = {16'h0, half_sel};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline MEM stage: data-cache handshake and MEM/WB register
// Purpose: issues loads/stores to the data cache, stalls EX/MEM until the
//   cache answers, and fills the MEM/WB register (bubbles while waiting).
// Optional build macro: MISALIGN_TRAP_EN (adds misalign port; misaligned
//   half/word accesses skip the cache and retire in one cycle with regwriteW=0).
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   regsrcM/regwriteM/memreadM/memwriteM, f3M, aluout, B, rdM   EX/MEM inputs
//   memhazard                       hold EX/MEM when 1
//   dc_req/dc_we/dc_addr/dc_wdata/dc_wstrb, dc_rdata/dc_ready  data cache
//   regwriteW/regsrcW/rdW/aluoutW/memdataW                     MEM/WB register
//   misalign                        misaligned-access flag (MISALIGN_TRAP_EN only)
module mem_access
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        regsrcM,
  input  logic        regwriteM,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [2:0]  f3M,
  input  logic [31:0] aluout,
  input  logic [31:0] B,
  input  logic [4:0]  rdM,
  output logic        memhazard,
  output logic        dc_req,
  output logic        dc_we,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_wdata,
  output logic [3:0]  dc_wstrb,
  input  logic [31:0] dc_rdata,
  input  logic        dc_ready,
  output logic        regwriteW,
  output logic        regsrcW,
  output logic [4:0]  rdW,
  output logic [31:0] aluoutW,
  output logic [31:0] memdataW
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  state_t      state_q, state_d;
  logic        regwrite_w_q, regwrite_w_d;
  logic        regsrc_w_q, regsrc_w_d;
  logic [4:0]  rd_w_q, rd_w_d;
  logic [31:0] aluout_w_q, aluout_w_d;
  logic [31:0] memdata_w_q, memdata_w_d;

  logic        memop;
  logic        mis_access;
  logic        is_byte;
  logic        is_half;
  logic [31:0] load_data;

  assign memop   = memreadM | memwriteM;
  assign is_byte = (f3M[1:0] == F3_B[1:0]);
  assign is_half = (f3M[1:0] == F3_H[1:0]);

`ifdef MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign mis_access = (is_half & aluout[0]) | (f3M[1] & (aluout[1:0] != 2'b00));
  assign misalign   = misalign_q;
`else
  assign mis_access = 1'b0;
`endif

  // Request fields come straight from EX/MEM; memhazard keeps them stable.
  assign dc_addr = {aluout[31:2], 2'b00};
  assign dc_we   = memwriteM;

  always_comb begin
    if (is_byte) begin
      dc_wstrb = 4'b0001 << aluout[1:0];
      dc_wdata = {4{B[7:0]}};
    end else if (is_half) begin
      dc_wstrb = 4'b0011 << {aluout[1], 1'b0};
      dc_wdata = {2{B[15:0]}};
    end else begin
      dc_wstrb = 4'b1111;
      dc_wdata = B;
    end
  end

  load_extend u_load_extend (
    .rdata_i  (dc_rdata),
    .addr_i   (aluout[1:0]),
    .f3_i     (f3M),
    .result_o (load_data)
  );

  always_comb begin
    state_d      = state_q;
    dc_req       = 1'b0;
    memhazard    = 1'b0;
    regwrite_w_d = regwriteM;
    regsrc_w_d   = regsrcM;
    rd_w_d       = rdM;
    aluout_w_d   = aluout;
    memdata_w_d  = 32'h0;
`ifdef MISALIGN_TRAP_EN
    misalign_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // dc_ready is deliberately not looked at here.
        if (memop) begin
          if (mis_access) begin
            regwrite_w_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_d   = 1'b1;
`endif
          end else begin
            dc_req       = 1'b1;
            memhazard    = 1'b1;
            regwrite_w_d = 1'b0;
            regsrc_w_d   = 1'b0;
            rd_w_d       = 5'd0;
            aluout_w_d   = 32'h0;
            state_d      = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        dc_req = 1'b1;
        if (dc_ready) begin
          // Release the stall in the completing cycle so EX/MEM advances.
          memdata_w_d = memwriteM ? 32'h0 : load_data;
          state_d     = ST_IDLE;
        end else begin
          memhazard    = 1'b1;
          regwrite_w_d = 1'b0;
          regsrc_w_d   = 1'b0;
          rd_w_d       = 5'd0;
          aluout_w_d   = 32'h0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      regwrite_w_q <= 1'b0;
      regsrc_w_q   <= 1'b0;
      rd_w_q       <= 5'd0;
      aluout_w_q   <= 32'h0;
      memdata_w_q  <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      regwrite_w_q <= regwrite_w_d;
      regsrc_w_q   <= regsrc_w_d;
      rd_w_q       <= rd_w_d;
      aluout_w_q   <= aluout_w_d;
      memdata_w_q  <= memdata_w_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign regwriteW = regwrite_w_q;
  assign regsrcW   = regsrc_w_q;
  assign rdW       = rd_w_q;
  assign aluoutW   = aluout_w_q;
  assign memdataW  = memdata_w_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access (table vectors + random model)
module tb_mem_access;

  logic        clk, rst;
  logic        regsrcM, regwriteM, memreadM, memwriteM;
  logic [2:0]  f3M;
  logic [31:0] aluout, B;
  logic [4:0]  rdM;
  logic        memhazard, dc_req, dc_we;
  logic [31:0] dc_addr, dc_wdata;
  logic [3:0]  dc_wstrb;
  logic [31:0] dc_rdata;
  logic        dc_ready;
  logic        regwriteW, regsrcW;
  logic [4:0]  rdW;
  logic [31:0] aluoutW, memdataW;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int checks   = 0;
  int failures = 0;

  mem_access dut (
    .clk(clk), .rst(rst),
    .regsrcM(regsrcM), .regwriteM(regwriteM), .memreadM(memreadM), .memwriteM(memwriteM),
    .f3M(f3M), .aluout(aluout), .B(B), .rdM(rdM),
    .memhazard(memhazard), .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb), .dc_rdata(dc_rdata), .dc_ready(dc_ready),
    .regwriteW(regwriteW), .regsrcW(regsrcW), .rdW(rdW), .aluoutW(aluoutW),
    .memdataW(memdataW)
`ifdef MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] b;
    logic [31:0] rdata;
    logic        rw;
    logic        rs;
    logic [4:0]  rd;
    logic [1:0]  waits;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] mdata;
    logic        mis;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference model: access size in bytes and the naturally aligned lane offset.
  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = acc_size(f3);
    return int'(a[1:0]) - (int'(a[1:0]) % sz);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    int sz;
    logic [31:0] v, mask;
    sz = acc_size(f3);
    v  = rdata >> (8 * lane_off(f3, a));
    if (sz < 4) begin
      mask = (32'h1 << (8 * sz)) - 32'h1;
      v    = v & mask;
      if ((f3 == 3'b000 || f3 == 3'b001) && v[8*sz-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic vec_t model_vec();
    vec_t v;
    int   kind, sz, off;
    kind    = int'($urandom_range(0, 7));
    v.rd_en = (kind >= 2 && kind <= 5) || kind == 7;
    v.wr_en = (kind == 6) || (kind == 7) || (kind == 1);
    if (kind == 0) begin v.rd_en = 1'b0; v.wr_en = 1'b0; end
    v.f3    = 3'($urandom_range(0, 7));
    v.addr  = $urandom;
    v.b     = $urandom;
    v.rdata = $urandom;
    v.rw    = 1'($urandom_range(0, 1));
    v.rs    = 1'($urandom_range(0, 1));
    v.rd    = 5'($urandom_range(0, 31));
    v.waits = 2'($urandom_range(0, 3));
    sz      = acc_size(v.f3);
    off     = lane_off(v.f3, v.addr);
    v.wstrb = 4'(((1 << sz) - 1) << off);
    for (int i = 0; i < 4; i++) v.wdata[8*i +: 8] = v.b[8*(i % sz) +: 8];
    v.mdata = v.wr_en ? 32'h0 : model_load(v.f3, v.addr, v.rdata);
    v.mis   = (v.rd_en | v.wr_en) && sz > 1 && (int'(v.addr[1:0]) % sz) != 0;
    return v;
  endfunction

  // Drives one EX/MEM slot (entered just after a rising edge, DUT idle) and
  // checks the cache handshake, the stall length and the MEM/WB result.
  task automatic run_op(input vec_t v, input string tag);
    logic trap;
    int   stalls;
`ifdef MISALIGN_TRAP_EN
    trap = v.mis;
`else
    trap = 1'b0;
`endif
    memreadM = v.rd_en; memwriteM = v.wr_en; f3M = v.f3; aluout = v.addr; B = v.b;
    dc_rdata = v.rdata; regwriteM = v.rw; regsrcM = v.rs; rdM = v.rd; dc_ready = 1'b0;
    stalls = 0;
    if (!(v.rd_en | v.wr_en) || trap) begin
      @(negedge clk);
      chk({tag, ".hz"}, 32'(memhazard), 32'h0);
      chk({tag, ".req"}, 32'(dc_req), 32'h0);
      @(posedge clk); #1;
      chk({tag, ".regwriteW"}, 32'(regwriteW), 32'(v.rw & ~trap));
      chk({tag, ".rdW"}, 32'(rdW), 32'(v.rd));
      chk({tag, ".regsrcW"}, 32'(regsrcW), 32'(v.rs));
      chk({tag, ".aluoutW"}, aluoutW, v.addr);
      chk({tag, ".memdataW"}, memdataW, 32'h0);
`ifdef MISALIGN_TRAP_EN
      chk({tag, ".misalign"}, 32'(misalign), 32'(trap));
`endif
    end else begin
      @(negedge clk);
      chk({tag, ".req"}, 32'(dc_req), 32'h1);
      if (memhazard) stalls++;
      chk({tag, ".addr"}, dc_addr, {v.addr[31:2], 2'b00});
      chk({tag, ".we"}, 32'(dc_we), 32'(v.wr_en));
      if (v.wr_en) begin
        chk({tag, ".wstrb"}, 32'(dc_wstrb), 32'(v.wstrb));
        chk({tag, ".wdata"}, dc_wdata, v.wdata);
      end
      for (int w = 0; w < int'(v.waits); w++) begin
        @(posedge clk); #1;
        chk({tag, ".bubble_rw"}, 32'(regwriteW), 32'h0);
        chk({tag, ".bubble_rd"}, 32'(rdW), 32'h0);
        @(negedge clk);
        chk({tag, ".wait_req"}, 32'(dc_req), 32'h1);
        if (memhazard) stalls++;
        chk({tag, ".wait_addr"}, dc_addr, {v.addr[31:2], 2'b00});
      end
      @(posedge clk); #1;
      chk({tag, ".bubble_rw"}, 32'(regwriteW), 32'h0);
      chk({tag, ".bubble_rd"}, 32'(rdW), 32'h0);
      dc_ready = 1'b1;
      @(negedge clk);
      chk({tag, ".done_hz"}, 32'(memhazard), 32'h0);
      chk({tag, ".done_req"}, 32'(dc_req), 32'h1);
      @(posedge clk); #1;
      dc_ready = 1'b0;
      chk({tag, ".stalls"}, 32'(stalls), 32'(1 + int'(v.waits)));
      chk({tag, ".regwriteW"}, 32'(regwriteW), 32'(v.rw));
      chk({tag, ".rdW"}, 32'(rdW), 32'(v.rd));
      chk({tag, ".regsrcW"}, 32'(regsrcW), 32'(v.rs));
      chk({tag, ".aluoutW"}, aluoutW, v.addr);
      chk({tag, ".memdataW"}, memdataW, v.mdata);
`ifdef MISALIGN_TRAP_EN
      chk({tag, ".misalign"}, 32'(misalign), 32'h0);
`endif
    end
    memreadM = 1'b0; memwriteM = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         rd wr  f3      addr          b             rdata         rw   rs   rd     waits wstrb  wdata         mdata         mis
    tbl[0]  = '{1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0,         32'h0,         1'b1, 1'b0, 5'd5,  2'd0, 4'h0, 32'h0,         32'h0,         1'b0};
    tbl[1]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hABCD_1234, 32'h0,         1'b0, 1'b0, 5'd3,  2'd1, 4'hC, 32'h1234_1234, 32'h0,         1'b0};
    tbl[2]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'h0,         1'b0, 1'b0, 5'd3,  2'd0, 4'h2, 32'hA5A5_A5A5, 32'h0,         1'b0};
    tbl[3]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1, 5'd2,  2'd2, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0};
    tbl[4]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0,         32'hBEEF_0000, 1'b1, 1'b1, 5'd9,  2'd0, 4'h0, 32'h0,         32'h0000_BEEF, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_0000, 1'b1, 1'b1, 5'd4,  2'd3, 4'h0, 32'h0,         32'hFFFF_FF80, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0,         32'h1234_8756, 1'b1, 1'b1, 5'd13, 2'd1, 4'h0, 32'h0,         32'h0000_0087, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0000, 32'h0,         32'h0000_8001, 1'b1, 1'b1, 5'd14, 2'd0, 4'h0, 32'h0,         32'hFFFF_8001, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0004, 32'h0,         32'hCAFE_BABE, 1'b1, 1'b1, 5'd15, 2'd1, 4'h0, 32'h0,         32'hCAFE_BABE, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0008, 32'h0,         32'h0102_0304, 1'b1, 1'b0, 5'd16, 2'd0, 4'h0, 32'h0,         32'h0102_0304, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 3'b010, 32'h0000_0030, 32'h0000_0005, 32'h0,         1'b1, 1'b0, 5'd6,  2'd0, 4'hF, 32'h0000_0005, 32'h0,         1'b0};
    tbl[11] = '{1'b1, 1'b1, 3'b010, 32'h0000_0020, 32'h1122_3344, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd7,  2'd1, 4'hF, 32'h1122_3344, 32'h0,         1'b0};
    tbl[12] = '{1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0000_BEEF, 32'h0,         1'b0, 1'b0, 5'd3,  2'd0, 4'hC, 32'hBEEF_BEEF, 32'h0,         1'b1};
    tbl[13] = '{1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0,         32'h8000_1234, 1'b1, 1'b1, 5'd17, 2'd0, 4'h0, 32'h0,         32'hFFFF_8000, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0,         32'h0A0B_0C0D, 1'b1, 1'b1, 5'd8,  2'd0, 4'h0, 32'h0,         32'h0A0B_0C0D, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 3'b101, 32'h0000_0001, 32'h0,         32'h0000_F00F, 1'b1, 1'b1, 5'd18, 2'd2, 4'h0, 32'h0,         32'h0000_F00F, 1'b1};

    // Reset: WB-path inputs busy, MEM/WB must still clear.
    rst = 1'b1; dc_ready = 1'b0; dc_rdata = 32'h0;
    memreadM = 1'b0; memwriteM = 1'b0; f3M = 3'b000; B = 32'h0;
    regwriteM = 1'b1; regsrcM = 1'b1; rdM = 5'd7; aluout = 32'h0000_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.regwriteW", 32'(regwriteW), 32'h0);
    chk("rst.regsrcW", 32'(regsrcW), 32'h0);
    chk("rst.rdW", 32'(rdW), 32'h0);
    chk("rst.aluoutW", aluoutW, 32'h0);
    chk("rst.memdataW", memdataW, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("rst.misalign", 32'(misalign), 32'h0);
`endif
    rst = 1'b0; regwriteM = 1'b0; regsrcM = 1'b0; rdM = 5'd0; aluout = 32'h0;
    @(negedge clk);
    chk("rst.req", 32'(dc_req), 32'h0);
    chk("rst.hz", 32'(memhazard), 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // dc_ready already high in IDLE must not shorten the access.
    memreadM = 1'b1; f3M = 3'b010; aluout = 32'h40; dc_rdata = 32'h1357_9BDF;
    regwriteM = 1'b1; regsrcM = 1'b1; rdM = 5'd11; dc_ready = 1'b1;
    @(negedge clk);
    chk("early_rdy.hz", 32'(memhazard), 32'h1);
    chk("early_rdy.req", 32'(dc_req), 32'h1);
    @(posedge clk); #1;
    chk("early_rdy.bubble", 32'(regwriteW), 32'h0);
    @(negedge clk);
    chk("early_rdy.done_hz", 32'(memhazard), 32'h0);
    @(posedge clk); #1;
    chk("early_rdy.regwriteW", 32'(regwriteW), 32'h1);
    chk("early_rdy.memdataW", memdataW, 32'h1357_9BDF);
    memreadM = 1'b0; dc_ready = 1'b0; regwriteM = 1'b0; rdM = 5'd0;

    // Reset while waiting abandons the request; a late dc_ready is ignored.
    memreadM = 1'b1; f3M = 3'b010; aluout = 32'h80; rdM = 5'd12; regwriteM = 1'b1;
    dc_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wait.req_before", 32'(dc_req), 32'h1);
    rst = 1'b1; memreadM = 1'b0; regwriteM = 1'b0; rdM = 5'd0;
    @(posedge clk); #1;
    rst = 1'b0; dc_ready = 1'b1;
    @(negedge clk);
    chk("rst_wait.req", 32'(dc_req), 32'h0);
    chk("rst_wait.hz", 32'(memhazard), 32'h0);
    @(posedge clk); #1;
    dc_ready = 1'b0;
    chk("rst_wait.regwriteW", 32'(regwriteW), 32'h0);
    chk("rst_wait.rdW", 32'(rdW), 32'h0);
    chk("rst_wait.memdataW", memdataW, 32'h0);
    @(negedge clk);
    chk("rst_wait.req_after", 32'(dc_req), 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++) run_op(model_vec(), $sformatf("rnd%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
